// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_scan display driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-high, for a common-cathode display.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic DP_OFF = 1'b0;

endpackage

// File: rtl/seg7_scan_hex2seg.sv
// Combinational hex nibble to seven-segment pattern lookup.
module hex2seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner: BLANK/SHOW slot per digit, value latched per frame.
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses segments of leading-zero digits above digit 0.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_mhz   = 50,
  parameter int DIGITS    = 4,
  parameter int SCAN_hz   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  data_vld,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame
);

  localparam int TICK = CLK_mhz * 1000 * 1000 / SCAN_hz;
  localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW   = 4 * DIGITS;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  if (BLANK_CYC < 1 || BLANK_CYC >= TICK) begin : g_bad_blank
    $error("seg7_scan: BLANK_CYC must satisfy 1 <= BLANK_CYC < TICK");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     pending_q, pending_d;
  logic [DW-1:0]     shown_q, shown_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;
  logic              frame_q, frame_d;
  logic [3:0]        nib;
  logic [6:0]        seg7;
  logic              lz_blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      shown_q   <= '0;
      seg_q     <= '0;
      dig_en_q  <= '0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      frame_q   <= frame_d;
    end
  end

  // Prescaler runs through the whole slot; the state only marks where blanking ends.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    pending_d = data_vld ? data : pending_q;
    shown_d   = shown_q;
    frame_d   = 1'b0;
    case (state_q)
      BLANK: begin
        presc_d = presc_q + PW'(1);
        if (presc_q == BLANK_LAST) state_d = SHOW;
      end
      SHOW: begin
        if (presc_q == TICK_LAST) begin
          presc_d = '0;
          state_d = BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            frame_d = 1'b1;
            shown_d = data_vld ? data : pending_q;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = BLANK;
        presc_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign nib = shown_d[4*idx_d +: 4];

  hex2seg u_hex2seg (
    .nib_i (nib),
    .seg_o (seg7)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q, blank_d;

  always_ff @(posedge clk) begin
    if (!rst_n) blank_q <= BLANK_RST;
    else        blank_q <= blank_d;
  end

  always_comb begin
    blank_d = blank_q;
    if (frame_d) begin
      blank_d[0] = 1'b0;
      for (int k = 1; k < DIGITS; k++) begin
        blank_d[k] = ((shown_d >> (4 * k)) == '0);
      end
    end
  end

  assign lz_blank = blank_q[idx_d];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_d    = '0;
    dig_en_d = '0;
    if (state_d == SHOW) begin
      dig_en_d = DIGITS'(1) << idx_d;
      if (!lz_blank) seg_d = {DP_OFF, seg7};
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with TICK=10, BLANK_CYC=2, DIGITS=4; expected outputs come from
// a cycle-count model of the scan timetable and a per-frame snapshot of the strobed value.
module tb_seg7_scan;

  localparam int CLK_MHZ = 1;
  localparam int SCAN_HZ = 100000;
  localparam int BLANK   = 2;
  localparam int DIGITS  = 4;
  localparam int TICK    = CLK_MHZ * 1000 * 1000 / SCAN_HZ;
  localparam int FRAME   = DIGITS * TICK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        data_vld = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig_en;
  logic        frame;

  int total = 0;
  int bad   = 0;

  // Model: t counts edges since the last reset edge; disp is the value shown in the current frame.
  int          t = 0;
  logic [15:0] pend = '0;
  logic [15:0] disp = '0;
  logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan #(
    .CLK_mhz   (CLK_MHZ),
    .DIGITS    (DIGITS),
    .SCAN_hz   (SCAN_HZ),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .data_vld (data_vld),
    .seg      (seg),
    .dig_en   (dig_en),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      t    = 0;
      pend = '0;
      disp = '0;
    end else begin
      t++;
      if (t % FRAME == 0) disp = data_vld ? data : pend;
      if (data_vld) pend = data;
    end
    #1;
  endtask

  function automatic logic [12:0] exp_out();
    int          pos;
    int          slot;
    logic [15:0] upper;
    logic [7:0]  s;
    logic [3:0]  d;
    logic        f;
    pos   = t % TICK;
    slot  = (t / TICK) % DIGITS;
    f     = (t > 0) && (t % FRAME == 0);
    s     = '0;
    d     = '0;
    upper = disp >> (4 * slot);
    if (pos >= BLANK) begin
      d = 4'(1 << slot);
      s = {1'b0, lut[upper[3:0]]};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (slot > 0 && upper == 16'h0) s = '0;
`endif
    end
    return {s, d, f};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({seg, dig_en, frame} !== 13'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=0", i, {seg, dig_en, frame});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [12:0] want;
    for (int i = 0; i < 45; i++) begin
      cyc();
      want = exp_out();
      total++;
      if ({seg, dig_en, frame} !== want) begin
        bad++;
        $display("FAIL idle_scan t=%0d got=%h want=%h", t, {seg, dig_en, frame}, want);
      end
      if (t == 40) begin
        total++;
        if (frame !== 1'b1) begin
          bad++;
          $display("FAIL first_frame t=%0d got=%b want=1", t, frame);
        end
      end
    end
  endtask

  task automatic test_capture_mid_frame();
    logic [12:0] want;
    logic [7:0]  next_seg [4];
    int          n;
    int          start;
    next_seg = '{8'h71, 8'h7F, 8'h77, 8'h06};
    n = (FRAME + 15 - t % FRAME) % FRAME;
    for (int i = 0; i < n; i++) cyc();
    start = t;
    data = 16'h1A8F;
    data_vld = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      data_vld = 1'b0;
      want = exp_out();
      total++;
      if ({seg, dig_en, frame} !== want) begin
        bad++;
        $display("FAIL capture t=%0d got=%h want=%h", t, {seg, dig_en, frame}, want);
      end
      if (t % TICK == 5) begin
        total++;
        if (t / FRAME == start / FRAME) begin
          if (seg !== 8'h3F) begin
            bad++;
            $display("FAIL capture_old t=%0d got=%h want=3f", t, seg);
          end
        end else if (seg !== next_seg[(t / TICK) % DIGITS]) begin
          bad++;
          $display("FAIL capture_new t=%0d got=%h want=%h", t, seg, next_seg[(t / TICK) % DIGITS]);
        end
      end
    end
  endtask

  task automatic test_two_strobes();
    logic [12:0] want;
    int          n;
    n = (FRAME + 5 - t % FRAME) % FRAME;
    for (int i = 0; i < n; i++) cyc();
    for (int i = 0; i < 2 * FRAME; i++) begin
      data_vld = 1'b0;
      if (i == 0)  begin data = 16'h1234; data_vld = 1'b1; end
      if (i == 15) begin data = 16'hABCD; data_vld = 1'b1; end
      cyc();
      data_vld = 1'b0;
      want = exp_out();
      total++;
      if ({seg, dig_en, frame} !== want) begin
        bad++;
        $display("FAIL two_strobes t=%0d got=%h want=%h", t, {seg, dig_en, frame}, want);
      end
    end
  endtask

  task automatic test_boundary_strobe();
    logic [12:0] want;
    int          n;
    n = (FRAME + FRAME - 1 - t % FRAME) % FRAME;
    for (int i = 0; i < n; i++) cyc();
    data = 16'h00F0;
    data_vld = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      data_vld = 1'b0;
      want = exp_out();
      total++;
      if ({seg, dig_en, frame} !== want) begin
        bad++;
        $display("FAIL boundary t=%0d got=%h want=%h", t, {seg, dig_en, frame}, want);
      end
      if (i == 0) begin
        total++;
        if (frame !== 1'b1) begin
          bad++;
          $display("FAIL boundary_frame got=%b want=1", frame);
        end
      end
      if (i == TICK + 5) begin
        total++;
        if (seg !== 8'h71) begin
          bad++;
          $display("FAIL boundary_digit1 got=%h want=71", seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [12:0] want;
    int          n;
    data = 16'h5A5A;
    data_vld = 1'b1;
    cyc();
    data_vld = 1'b0;
    n = (FRAME + 26 - t % FRAME) % FRAME;
    for (int i = 0; i < n; i++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    total++;
    if ({seg, dig_en, frame} !== 13'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=0", {seg, dig_en, frame});
    end
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      cyc();
      want = exp_out();
      total++;
      if ({seg, dig_en, frame} !== want) begin
        bad++;
        $display("FAIL after_reset t=%0d got=%h want=%h", t, {seg, dig_en, frame}, want);
      end
      if (t == FRAME) begin
        total++;
        if (frame !== 1'b1) begin
          bad++;
          $display("FAIL after_reset_frame t=%0d got=%b want=1", t, frame);
        end
      end
    end
  endtask

  task automatic test_patterns();
    logic [12:0] want;
    logic [15:0] pats [6];
    pats = '{16'h0050, 16'h0000, 16'h0007, 16'h8000, 16'h0300, 16'hFFFF};
    for (int p = 0; p < 6; p++) begin
      data = pats[p];
      data_vld = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
        cyc();
        data_vld = 1'b0;
        want = exp_out();
        total++;
        if ({seg, dig_en, frame} !== want) begin
          bad++;
          $display("FAIL pattern %h t=%0d got=%h want=%h", pats[p], t, {seg, dig_en, frame}, want);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] want;
    for (int i = 0; i < 600; i++) begin
      data_vld = ($urandom_range(0, 7) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
      cyc();
      data_vld = 1'b0;
      want = exp_out();
      total++;
      if ({seg, dig_en, frame} !== want) begin
        bad++;
        $display("FAIL random t=%0d got=%h want=%h", t, {seg, dig_en, frame}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_capture_mid_frame();
    test_two_strobes();
    test_boundary_strobe();
    test_reset_mid_scan();
    test_patterns();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
